// File: rtl/t08_pkg.sv
// Shared types and constants for the t08 MMIO bridge.
// Covers the FSM states, the default address map and the bus error word.
package t08_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUS      = 2'd1,
    I2C_WAIT = 2'd2,
    RESP     = 2'd3
  } state_t;

  localparam logic [31:0] RAM_LIMIT_DEF = 32'd2048;
  localparam logic [31:0] I2C_ADDR_DEF  = 32'd923923;
  localparam logic [31:0] WB_BASE_DEF   = 32'h3300_0000;
  localparam int          TIMEOUT_DEF   = 255;
  localparam logic [31:0] ERR_WORD      = 32'hDEAD_BEEF;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/t08_i2c_holdreg.sv
// Holds the latest I2C sensor word and tracks whether it is still unread.
// A new pulse always wins over a read that consumes the held word.
module t08_i2c_holdreg (
  input  logic        clk,
  input  logic        nrst,
  input  logic        i2c_valid,
  input  logic [31:0] i2c_data,
  input  logic        take_held,
  input  logic        take_live,
  output logic [31:0] word,
  output logic        fresh
);

  logic [31:0] held_r;
  logic        fresh_r;

  // Load the holding register and update the fresh flag.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      held_r  <= 32'd0;
      fresh_r <= 1'b0;
    end else begin
      if (i2c_valid) begin
        held_r <= i2c_data;
      end
      // A waiting read consumes the very pulse it was waiting for.
      if (take_live) begin
        fresh_r <= 1'b0;
      end else if (i2c_valid) begin
        fresh_r <= 1'b1;
      end else if (take_held) begin
        fresh_r <= 1'b0;
      end
    end
  end

  assign word  = i2c_valid ? i2c_data : held_r;
  assign fresh = fresh_r;

endmodule

// File: rtl/t08_mmio_bridge.sv
// Bridges memory-handler requests to Wishbone memory or the I2C data register.
// Produces the busy/done/err handshake the handler uses to freeze the core.
module t08_mmio_bridge
  import t08_pkg::*;
#(
  parameter logic [31:0] RAM_LIMIT = RAM_LIMIT_DEF,
  parameter logic [31:0] I2C_ADDR  = I2C_ADDR_DEF,
  parameter logic [31:0] WB_BASE   = WB_BASE_DEF,
  parameter int          TIMEOUT   = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic [31:0] i2c_data,
  input  logic        i2c_valid
);

  localparam int               CNT_W       = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic [31:0]      rdata_r;
  logic             done_r;
  logic             err_r;
  logic             cyc_r;
  logic             stb_r;
  logic             we_r;
  logic [31:0]      adr_r;
  logic [31:0]      dat_r;
  logic [3:0]       sel_r;
  logic             is_ram_s;
  logic             is_i2c_s;
  logic             take_held_s;
  logic             take_live_s;
  logic [31:0]      i2c_word_s;
  logic             fresh_s;

  t08_i2c_holdreg u_holdreg (
    .clk       (clk),
    .nrst      (nrst),
    .i2c_valid (i2c_valid),
    .i2c_data  (i2c_data),
    .take_held (take_held_s),
    .take_live (take_live_s),
    .word      (i2c_word_s),
    .fresh     (fresh_s)
  );

  // Address decode and holding-register consume strobes.
  always_comb begin
    is_ram_s    = (req_addr < RAM_LIMIT);
    is_i2c_s    = (req_addr == I2C_ADDR);
    cnt_next_s  = cnt_r + CNT_ONE;
    take_held_s = 1'b0;
    take_live_s = 1'b0;
    if ((state_r == IDLE) && req_read && !req_write && is_i2c_s && fresh_s) begin
      take_held_s = 1'b1;
    end else begin
      take_held_s = 1'b0;
    end
    if ((state_r == I2C_WAIT) && i2c_valid) begin
      take_live_s = 1'b1;
    end else begin
      take_live_s = 1'b0;
    end
  end

  // Access sequencer with registered bus and handshake outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      rdata_r <= 32'd0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      cyc_r   <= 1'b0;
      stb_r   <= 1'b0;
      we_r    <= 1'b0;
      adr_r   <= 32'd0;
      dat_r   <= 32'd0;
      sel_r   <= 4'h0;
    end else begin
      sel_r  <= 4'hF;
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req_write) begin
            if (is_ram_s) begin
              adr_r   <= WB_BASE + word_align(req_addr);
              dat_r   <= req_wdata;
              we_r    <= 1'b1;
              cyc_r   <= 1'b1;
              stb_r   <= 1'b1;
              cnt_r   <= '0;
              state_r <= BUS;
            end else if (is_i2c_s) begin
              done_r  <= 1'b1;
              state_r <= RESP;
            end else begin
              done_r  <= 1'b1;
              err_r   <= 1'b1;
              state_r <= RESP;
            end
          end else if (req_read) begin
            if (is_ram_s) begin
              adr_r   <= WB_BASE + word_align(req_addr);
              we_r    <= 1'b0;
              cyc_r   <= 1'b1;
              stb_r   <= 1'b1;
              cnt_r   <= '0;
              state_r <= BUS;
            end else if (is_i2c_s) begin
              if (fresh_s) begin
                rdata_r <= i2c_word_s;
                done_r  <= 1'b1;
                state_r <= RESP;
              end else begin
                state_r <= I2C_WAIT;
              end
            end else begin
              rdata_r <= 32'd0;
              done_r  <= 1'b1;
              err_r   <= 1'b1;
              state_r <= RESP;
            end
          end
        end
        BUS: begin
          // An ack landing on the final counted cycle still completes normally.
          if (wb_ack_i) begin
            if (!we_r) begin
              rdata_r <= wb_dat_i;
            end
            cyc_r   <= 1'b0;
            stb_r   <= 1'b0;
            we_r    <= 1'b0;
            done_r  <= 1'b1;
            state_r <= RESP;
          end else if (cnt_next_s == TIMEOUT_CNT) begin
            if (!we_r) begin
              rdata_r <= ERR_WORD;
            end
            cnt_r   <= cnt_next_s;
            cyc_r   <= 1'b0;
            stb_r   <= 1'b0;
            we_r    <= 1'b0;
            done_r  <= 1'b1;
            err_r   <= 1'b1;
            state_r <= RESP;
          end else begin
            cnt_r <= cnt_next_s;
          end
        end
        I2C_WAIT: begin
          if (i2c_valid) begin
            rdata_r <= i2c_data;
            done_r  <= 1'b1;
            state_r <= RESP;
          end
        end
        RESP: begin
          state_r <= IDLE;
        end
        default: begin
          cyc_r   <= 1'b0;
          stb_r   <= 1'b0;
          we_r    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Busy must rise in the acceptance cycle, so it is decoded from the live request.
  assign busy = nrst & ((state_r == BUS) | (state_r == I2C_WAIT) |
                        ((state_r == IDLE) & (req_read | req_write)));

  assign rdata    = rdata_r;
  assign done     = done_r;
  assign err      = err_r;
  assign wb_cyc_o = cyc_r;
  assign wb_stb_o = stb_r;
  assign wb_we_o  = we_r;
  assign wb_adr_o = adr_r;
  assign wb_dat_o = dat_r;
  assign wb_sel_o = sel_r;

endmodule

// File: tb/tb_t08_mmio_bridge.sv
// Scoreboard bench for t08_mmio_bridge: expected completions are queued at request
// time and compared whenever the bridge pulses done.
module tb_t08_mmio_bridge;

  localparam logic [31:0] I2C_A = 32'd923923;

  logic        clk;
  logic        nrst;
  logic        req_read;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic [31:0] i2c_data;
  logic        i2c_valid;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          stb_bad  = 0;
  logic [31:0] last_rdata = 32'd0;
  logic [31:0] bus_adr;
  logic [31:0] bus_dat;
  logic        bus_we;
  logic [3:0]  bus_sel;
  int          busy_n;
  int          cyc_n;

  t08_mmio_bridge dut (
    .clk       (clk),
    .nrst      (nrst),
    .req_read  (req_read),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rdata     (rdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_we_o   (wb_we_o),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_sel_o  (wb_sel_o),
    .wb_dat_i  (wb_dat_i),
    .wb_ack_i  (wb_ack_i),
    .i2c_data  (i2c_data),
    .i2c_valid (i2c_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string name, input logic [31:0] rd, input logic e);
    exp_t x;
    x.name  = name;
    x.rdata = rd;
    x.err   = e;
    sb_q.push_back(x);
    last_rdata = rd;
  endtask

  // Pop and compare one expected completion per done pulse.
  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_val({mon_e.name, "_rdata"}, rdata, mon_e.rdata);
        check_val({mon_e.name, "_err"}, {31'd0, err}, {31'd0, mon_e.err});
      end
    end else if (err) begin
      check_val("err_without_done", {31'd0, err}, 32'd0);
    end
  end

  task automatic pulse_i2c(input logic [31:0] w);
    @(negedge clk);
    i2c_valid = 1'b1;
    i2c_data  = w;
    @(negedge clk);
    i2c_valid = 1'b0;
    i2c_data  = 32'd0;
  endtask

  // Drive one request, act as Wishbone slave / sensor, and hold until done.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input int ack_after,
                            input logic [31:0] ack_data, input int i2c_after,
                            input logic [31:0] i2c_word);
    int n;
    bit fin;
    n = 0;
    fin = 1'b0;
    busy_n = 0;
    cyc_n = 0;
    bus_adr = 32'd0;
    bus_dat = 32'd0;
    bus_we = 1'b0;
    bus_sel = 4'h0;
    @(negedge clk);
    req_read  = rd;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    #1;
    while (!fin && n < 400) begin
      if (done) begin
        fin = 1'b1;
      end else begin
        if (busy) busy_n++;
        if (wb_stb_o !== wb_cyc_o) stb_bad++;
        if (wb_cyc_o) begin
          cyc_n++;
          bus_adr = wb_adr_o;
          bus_dat = wb_dat_o;
          bus_we  = wb_we_o;
          bus_sel = wb_sel_o;
        end
        wb_ack_i  = wb_cyc_o && (cyc_n == ack_after);
        wb_dat_i  = wb_ack_i ? ack_data : 32'd0;
        i2c_valid = (n == i2c_after);
        i2c_data  = i2c_valid ? i2c_word : 32'd0;
        @(negedge clk);
        #1;
        n++;
      end
    end
    req_read  = 1'b0;
    req_write = 1'b0;
    wb_ack_i  = 1'b0;
    wb_dat_i  = 32'd0;
    i2c_valid = 1'b0;
    i2c_data  = 32'd0;
    check_val("access_completed", {31'd0, fin}, 32'd1);
    @(negedge clk);
    #1;
    check_val("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    nrst = 1'b0;
    req_read = 1'b0;
    req_write = 1'b0;
    req_addr = 32'd0;
    req_wdata = 32'd0;
    wb_dat_i = 32'd0;
    wb_ack_i = 1'b0;
    i2c_data = 32'd0;
    i2c_valid = 1'b0;
    #23;
    check_val("rst_rdata", rdata, 32'd0);
    check_val("rst_ctrl", {21'd0, busy, done, err, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o},
              32'd0);
    check_val("rst_adr", wb_adr_o, 32'd0);
    check_val("rst_dat", wb_dat_o, 32'd0);
    @(negedge clk);
    nrst = 1'b1;

    push_exp("rd10", 32'h1234_5678, 1'b0);
    run_access(1'b1, 1'b0, 32'h10, 32'd0, 1, 32'h1234_5678, -1, 32'd0);
    check_val("rd10_busy", busy_n, 32'd2);
    check_val("rd10_cyc", cyc_n, 32'd1);
    check_val("rd10_adr", bus_adr, 32'h3300_0010);
    check_val("rd10_sel", {28'd0, bus_sel}, 32'hF);
    check_val("rd10_we", {31'd0, bus_we}, 32'd0);

    push_exp("wr7fc", last_rdata, 1'b0);
    run_access(1'b0, 1'b1, 32'h7FC, 32'hCAFE_F00D, 3, 32'hFFFF_0000, -1, 32'd0);
    check_val("wr7fc_cyc", cyc_n, 32'd3);
    check_val("wr7fc_busy", busy_n, 32'd4);
    check_val("wr7fc_we", {31'd0, bus_we}, 32'd1);
    check_val("wr7fc_dat", bus_dat, 32'hCAFE_F00D);
    check_val("wr7fc_adr", bus_adr, 32'h3300_07FC);

    push_exp("rd_timeout", 32'hDEAD_BEEF, 1'b1);
    run_access(1'b1, 1'b0, 32'h100, 32'd0, -1, 32'd0, -1, 32'd0);
    check_val("timeout_cyc", cyc_n, 32'd255);
    check_val("timeout_busy", busy_n, 32'd256);

    push_exp("rd_ack_wins", 32'h5555_AAAA, 1'b0);
    run_access(1'b1, 1'b0, 32'h104, 32'd0, 255, 32'h5555_AAAA, -1, 32'd0);
    check_val("ack_wins_cyc", cyc_n, 32'd255);

    push_exp("i2c_wait1", 32'h0000_00AB, 1'b0);
    run_access(1'b1, 1'b0, I2C_A, 32'd0, -1, 32'd0, 3, 32'h0000_00AB);
    check_val("i2c_wait1_busy", busy_n, 32'd4);
    check_val("i2c_wait1_cyc", cyc_n, 32'd0);

    push_exp("i2c_wait2", 32'h0000_00CD, 1'b0);
    run_access(1'b1, 1'b0, I2C_A, 32'd0, -1, 32'd0, 5, 32'h0000_00CD);
    check_val("i2c_wait2_busy", busy_n, 32'd6);

    pulse_i2c(32'h0000_0011);
    push_exp("i2c_fresh", 32'h0000_0011, 1'b0);
    run_access(1'b1, 1'b0, I2C_A, 32'd0, -1, 32'd0, -1, 32'd0);
    check_val("i2c_fresh_busy", busy_n, 32'd1);

    pulse_i2c(32'h0000_0033);
    push_exp("i2c_same_cycle", 32'h0000_0022, 1'b0);
    run_access(1'b1, 1'b0, I2C_A, 32'd0, -1, 32'd0, 0, 32'h0000_0022);
    check_val("i2c_same_busy", busy_n, 32'd1);
    push_exp("i2c_kept", 32'h0000_0022, 1'b0);
    run_access(1'b1, 1'b0, I2C_A, 32'd0, -1, 32'd0, -1, 32'd0);
    check_val("i2c_kept_busy", busy_n, 32'd1);

    push_exp("both20", last_rdata, 1'b0);
    run_access(1'b1, 1'b1, 32'h20, 32'h0F0F_1234, 1, 32'hFFFF_FFFF, -1, 32'd0);
    check_val("both20_we", {31'd0, bus_we}, 32'd1);
    check_val("both20_dat", bus_dat, 32'h0F0F_1234);
    check_val("both20_adr", bus_adr, 32'h3300_0020);

    push_exp("unmap_rd", 32'd0, 1'b1);
    run_access(1'b1, 1'b0, 32'h5000, 32'd0, -1, 32'd0, -1, 32'd0);
    check_val("unmap_rd_busy", busy_n, 32'd1);
    check_val("unmap_rd_cyc", cyc_n, 32'd0);

    push_exp("unmap_wr", last_rdata, 1'b1);
    run_access(1'b0, 1'b1, 32'h5000, 32'h1111_2222, -1, 32'd0, -1, 32'd0);
    check_val("unmap_wr_cyc", cyc_n, 32'd0);

    push_exp("i2c_wr", last_rdata, 1'b0);
    run_access(1'b0, 1'b1, I2C_A, 32'h7777_7777, -1, 32'd0, -1, 32'd0);
    check_val("i2c_wr_busy", busy_n, 32'd1);
    check_val("i2c_wr_cyc", cyc_n, 32'd0);

    // Reset in the middle of a Wishbone read.
    @(negedge clk);
    req_read = 1'b1;
    req_addr = 32'h40;
    @(negedge clk);
    #1;
    check_val("rst_mid_cyc_before", {31'd0, wb_cyc_o}, 32'd1);
    #2;
    nrst = 1'b0;
    #1;
    check_val("rst_mid_outs", {28'd0, wb_cyc_o, wb_stb_o, busy, done}, 32'd0);
    req_read = 1'b0;
    last_rdata = 32'd0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    check_val("rst_mid_rdata", rdata, 32'd0);

    push_exp("post_rst", 32'h0BAD_F00D, 1'b0);
    run_access(1'b1, 1'b0, 32'h10, 32'd0, 1, 32'h0BAD_F00D, -1, 32'd0);
    check_val("post_rst_busy", busy_n, 32'd2);

    repeat (3) @(negedge clk);
    check_val("stb_tracks_cyc", stb_bad, 32'd0);
    check_val("sb_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
